ova_sccb_target: RTL and testbench

- Synthesizable SCCB/I2C target (responder): the device-side counterpart of the camera-config I2C master driver.
- Oversamples scl/sda in the system clock domain, decodes START/STOP, matches the 7-bit device address, and ACKs.
- Holds a byte-wide register file with auto-increment for writes and reads.
- Used as an on-chip camera register model for loopback of the config path, and as a synthesizable bench target.

---
 rtl/ova_sccb_pkg.sv | 23 ++
 rtl/ova_sccb_line_sync.sv | 48 ++++
 rtl/ova_sccb_target.sv | 207 ++++++++++++++++++++
 tb/tb_ova_sccb_target.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ova_sccb_pkg.sv
// Shared types and constants for the SCCB/I2C target: FSM states, ID register values, bit counter width.
package ova_sccb_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_DEV_ADDR, S_DEV_ACK, S_RADDR_H, S_RADDR_L, S_RADDR_ACK,
        S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
    } sccb_state_t;

    localparam int         BIT_CNT_W   = 4;
    localparam logic [7:0] ID_PID      = 8'h76;
    localparam logic [7:0] ID_VER      = 8'h73;
    localparam logic [7:0] ID_PID_ADDR = 8'h0A;
    localparam logic [7:0] ID_VER_ADDR = 8'h0B;

    function automatic logic is_id_addr(input logic [15:0] a);
        return (a == {8'h00, ID_PID_ADDR}) || (a == {8'h00, ID_VER_ADDR});
    endfunction

    function automatic logic [7:0] id_value(input logic [15:0] a);
        return (a == {8'h00, ID_VER_ADDR}) ? ID_VER : ID_PID;
    endfunction

endpackage

// File: rtl/ova_sccb_line_sync.sv
// Synchronizes scl/sda into clk and flags scl edges plus bus START/STOP conditions.
module ova_sccb_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
    logic                   r_scl_d, r_sda_d;
    logic                   w_scl, w_sda;

    assign w_scl = r_scl_sync[SYNC_STAGES-1];
    assign w_sda = r_sda_sync[SYNC_STAGES-1];

    // Reset to the idle-bus level so leaving reset never looks like a START.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync[0] <= i_scl;
            r_sda_sync[0] <= i_sda;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_scl_sync[k] <= r_scl_sync[k-1];
                r_sda_sync[k] <= r_sda_sync[k-1];
            end
            r_scl_d <= w_scl;
            r_sda_d <= w_sda;
        end
    end

    assign o_sda      = w_sda;
    assign o_scl_rise = w_scl & ~r_scl_d;
    assign o_scl_fall = ~w_scl & r_scl_d;
    assign o_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign o_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

endmodule

// File: rtl/ova_sccb_target.sv
// SCCB/I2C target with byte register file and auto-increment pointer.
// Define OVA_TGT_ID_REG_EN to make 0x0A/0x0B read-only PID/VER constants.
module ova_sccb_target
    import ova_sccb_pkg::*;
#(
    parameter logic [6:0] DEVICE_ADDR = 7'h21,
    parameter logic       ADDR_NUM    = 1'b0,
    parameter int         REG_AW      = 8,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_scl,
    input  logic        i_sda,
    output logic        o_sda_oe,
    output logic        o_wr_vld,
    output logic [15:0] o_wr_addr,
    output logic [7:0]  o_wr_data,
    output logic        o_busy
);

    localparam logic [BIT_CNT_W-1:0] CNT7 = BIT_CNT_W'(7);
    localparam logic [BIT_CNT_W-1:0] CNT8 = BIT_CNT_W'(8);

    logic w_sda, w_rise, w_fall, w_start, w_stop;

    ova_sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk), .rst_n(rst_n), .i_scl(i_scl), .i_sda(i_sda),
        .o_sda(w_sda), .o_scl_rise(w_rise), .o_scl_fall(w_fall),
        .o_start(w_start), .o_stop(w_stop)
    );

    sccb_state_t          r_state;
    logic [BIT_CNT_W-1:0] r_bitcnt;
    logic [7:0]           r_shift, r_tx, r_addr_h;
    logic                 r_rw, r_lo_done, r_mack;
    logic                 r_oe_nxt, r_oe_upd, r_sda_oe;
    logic                 r_wr_vld, r_busy;
    logic [15:0]          r_wr_addr;
    logic [7:0]           r_wr_data;
    logic [REG_AW-1:0]    r_ptr;
    logic [7:0]           r_regs [0:(1<<REG_AW)-1];

    logic [7:0]        w_byte, w_rd_cur, w_rd_inc;
    logic [15:0]       w_addr16;
    logic [REG_AW-1:0] w_ptr_inc;
    logic              w_id_cur, w_id_inc, w_we;

    assign w_byte    = {r_shift[6:0], w_sda};
    assign w_addr16  = {(ADDR_NUM ? r_addr_h : 8'h00), r_shift};
    assign w_ptr_inc = r_ptr + REG_AW'(1);
    assign w_we      = w_rise && (r_state == S_WR_DATA) && (r_bitcnt == CNT7) && !w_id_cur;

    always_comb begin
`ifdef OVA_TGT_ID_REG_EN
        w_id_cur = is_id_addr(16'(r_ptr));
        w_id_inc = is_id_addr(16'(w_ptr_inc));
`else
        w_id_cur = 1'b0;
        w_id_inc = 1'b0;
`endif
        w_rd_cur = w_id_cur ? id_value(16'(r_ptr))     : r_regs[r_ptr];
        w_rd_inc = w_id_inc ? id_value(16'(w_ptr_inc)) : r_regs[w_ptr_inc];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < (1 << REG_AW); i++) r_regs[i] <= 8'h00;
        end else if (w_we) begin
            r_regs[r_ptr] <= w_byte;
        end
    end

    // Line drive is decided at the detected scl fall and applied one clk later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_bitcnt  <= '0;
            r_shift   <= 8'h00;
            r_tx      <= 8'h00;
            r_addr_h  <= 8'h00;
            r_rw      <= 1'b0;
            r_lo_done <= 1'b0;
            r_mack    <= 1'b1;
            r_oe_nxt  <= 1'b0;
            r_oe_upd  <= 1'b0;
            r_sda_oe  <= 1'b0;
            r_wr_vld  <= 1'b0;
            r_wr_addr <= 16'h0000;
            r_wr_data <= 8'h00;
            r_busy    <= 1'b0;
            r_ptr     <= '0;
        end else begin
            r_wr_vld <= 1'b0;
            r_oe_upd <= 1'b0;
            if (r_oe_upd) r_sda_oe <= r_oe_nxt;
            if (w_start) begin
                r_state  <= S_DEV_ADDR;
                r_bitcnt <= '0;
                r_sda_oe <= 1'b0;
            end else if (w_stop) begin
                r_state  <= S_IDLE;
                r_busy   <= 1'b0;
                r_sda_oe <= 1'b0;
            end else if (w_rise) begin
                case (r_state)
                    S_DEV_ADDR, S_RADDR_H, S_RADDR_L, S_WR_DATA: begin
                        r_shift  <= w_byte;
                        r_bitcnt <= r_bitcnt + 1'b1;
                    end
                    S_RD_DATA: r_bitcnt <= r_bitcnt + 1'b1;
                    S_RD_ACK:  r_mack   <= w_sda;
                    default: ;
                endcase
                if (w_we) begin
                    r_wr_vld  <= 1'b1;
                    r_wr_addr <= 16'(r_ptr);
                    r_wr_data <= w_byte;
                end
            end else if (w_fall) begin
                case (r_state)
                    S_DEV_ADDR: if (r_bitcnt == CNT8) begin
                        r_bitcnt <= '0;
                        r_rw     <= r_shift[0];
                        if (r_shift[7:1] == DEVICE_ADDR) begin
                            r_state  <= S_DEV_ACK;
                            r_busy   <= 1'b1;
                            r_oe_nxt <= 1'b1;
                            r_oe_upd <= 1'b1;
                        end else begin
                            r_state  <= S_IGNORE;
                        end
                    end
                    S_DEV_ACK: begin
                        r_oe_upd <= 1'b1;
                        if (r_rw) begin
                            r_state  <= S_RD_DATA;
                            r_oe_nxt <= ~w_rd_cur[7];
                            r_tx     <= {w_rd_cur[6:0], 1'b0};
                        end else begin
                            r_state  <= ADDR_NUM ? S_RADDR_H : S_RADDR_L;
                            r_oe_nxt <= 1'b0;
                        end
                    end
                    S_RADDR_H, S_RADDR_L: if (r_bitcnt == CNT8) begin
                        if (r_state == S_RADDR_H) r_addr_h <= r_shift;
                        else                      r_ptr    <= w_addr16[REG_AW-1:0];
                        r_lo_done <= (r_state == S_RADDR_L);
                        r_state   <= S_RADDR_ACK;
                        r_bitcnt  <= '0;
                        r_oe_nxt  <= 1'b1;
                        r_oe_upd  <= 1'b1;
                    end
                    S_RADDR_ACK: begin
                        r_state  <= r_lo_done ? S_WR_DATA : S_RADDR_L;
                        r_bitcnt <= '0;
                        r_oe_nxt <= 1'b0;
                        r_oe_upd <= 1'b1;
                    end
                    S_WR_DATA: if (r_bitcnt == CNT8) begin
                        r_state  <= S_WR_ACK;
                        r_bitcnt <= '0;
                        r_oe_nxt <= 1'b1;
                        r_oe_upd <= 1'b1;
                    end
                    S_WR_ACK: begin
                        r_state  <= S_WR_DATA;
                        r_ptr    <= w_ptr_inc;
                        r_oe_nxt <= 1'b0;
                        r_oe_upd <= 1'b1;
                    end
                    S_RD_DATA: begin
                        r_oe_upd <= 1'b1;
                        if (r_bitcnt == CNT8) begin
                            r_state  <= S_RD_ACK;
                            r_bitcnt <= '0;
                            r_oe_nxt <= 1'b0;
                        end else begin
                            r_oe_nxt <= ~r_tx[7];
                            r_tx     <= {r_tx[6:0], 1'b0};
                        end
                    end
                    S_RD_ACK: begin
                        r_oe_upd <= 1'b1;
                        if (!r_mack) begin
                            r_state  <= S_RD_DATA;
                            r_ptr    <= w_ptr_inc;
                            r_oe_nxt <= ~w_rd_inc[7];
                            r_tx     <= {w_rd_inc[6:0], 1'b0};
                        end else begin
                            r_state  <= S_IGNORE;
                            r_oe_nxt <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_sda_oe  = r_sda_oe;
    assign o_wr_vld  = r_wr_vld;
    assign o_wr_addr = r_wr_addr;
    assign o_wr_data = r_wr_data;
    assign o_busy    = r_busy;

endmodule

// File: tb/tb_ova_sccb_target.sv
// Bench: two targets (0x21/REG_AW=8 and 0x22/REG_AW=5) on one open-drain bus driven by a bit-banged master.
module tb_ova_sccb_target;

    localparam int Q = 10;

    logic        clk = 1'b0, rst_n = 1'b0, m_scl = 1'b1, m_sda = 1'b1;
    logic        sda_bus;
    logic        oe_a, vld_a, busy_a, oe_b, vld_b, busy_b;
    logic [15:0] addr_a, addr_b;
    logic [7:0]  data_a, data_b;

    assign sda_bus = m_sda & ~oe_a & ~oe_b;
    always #10 clk = ~clk;

    ova_sccb_target #(.DEVICE_ADDR(7'h21)) u_a (
        .clk(clk), .rst_n(rst_n), .i_scl(m_scl), .i_sda(sda_bus),
        .o_sda_oe(oe_a), .o_wr_vld(vld_a), .o_wr_addr(addr_a),
        .o_wr_data(data_a), .o_busy(busy_a));

    ova_sccb_target #(.DEVICE_ADDR(7'h22), .REG_AW(5)) u_b (
        .clk(clk), .rst_n(rst_n), .i_scl(m_scl), .i_sda(sda_bus),
        .o_sda_oe(oe_b), .o_wr_vld(vld_b), .o_wr_addr(addr_b),
        .o_wr_data(data_b), .o_busy(busy_b));

    typedef enum logic [2:0] {OP_START, OP_WR, OP_RD, OP_STOP, OP_BUSY} op_e;
    typedef struct {
        op_e         op;
        logic [7:0]  din;
        logic [7:0]  exp;
        logic        wr;
        logic        dev;
        logic [15:0] waddr;
    } vec_t;
    typedef struct {
        logic        dev;
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    vec_t vq[$];
    wr_t  sb[$];
    int   n_chk = 0, n_pass = 0;
    logic quiet_on = 1'b0, quiet_bad = 1'b0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    endtask

    function automatic void v(op_e op, logic [7:0] din, logic [7:0] exp,
                              logic wr = 1'b0, logic dev = 1'b0, logic [15:0] wa = 16'h0);
        vec_t t;
        t.op = op; t.din = din; t.exp = exp; t.wr = wr; t.dev = dev; t.waddr = wa;
        vq.push_back(t);
    endfunction
    function automatic void vs(); v(OP_START, 8'h00, 8'h00); endfunction
    function automatic void vp(); v(OP_STOP, 8'h00, 8'h00); endfunction
    function automatic void vw(logic [7:0] d, logic ack = 1'b0); v(OP_WR, d, {7'd0, ack}); endfunction
    function automatic void vws(logic [7:0] d, logic dev, logic [15:0] wa); v(OP_WR, d, 8'h00, 1'b1, dev, wa); endfunction
    function automatic void vr(logic mack, logic [7:0] e); v(OP_RD, {7'd0, mack}, e); endfunction
    function automatic void vb(logic e); v(OP_BUSY, 8'h00, {7'd0, e}); endfunction

    task automatic wq(); repeat (Q) @(negedge clk); endtask

    task automatic bit_out(input logic b, output logic s);
        wq(); m_sda = b; wq(); m_scl = 1'b1; wq(); s = sda_bus; wq(); m_scl = 1'b0;
    endtask

    task automatic i2c_start();
        if (!m_scl) begin wq(); m_sda = 1'b1; wq(); m_scl = 1'b1; wq(); end
        m_sda = 1'b0; wq(); m_scl = 1'b0;
    endtask

    task automatic i2c_stop();
        wq(); m_sda = 1'b0; wq(); m_scl = 1'b1; wq(); m_sda = 1'b1; wq();
    endtask

    task automatic i2c_wr(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_out(d[i], s);
        bit_out(1'b1, ack);
    endtask

    task automatic i2c_rd(input logic mack, output logic [7:0] d, output logic rel);
        logic s;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin bit_out(1'b1, s); d = {d[6:0], s}; end
        wq(); m_sda = mack; wq(); m_scl = 1'b1; wq();
        rel = !(oe_a || oe_b);
        wq(); m_scl = 1'b0;
    endtask

    task automatic run(input int lo, input int hi);
        logic       a, rel;
        logic [7:0] d;
        for (int i = lo; i < hi; i++) begin
            case (vq[i].op)
                OP_START: i2c_start();
                OP_STOP:  i2c_stop();
                OP_WR: begin
                    if (vq[i].wr) sb.push_back('{dev: vq[i].dev, addr: vq[i].waddr, data: vq[i].din});
                    i2c_wr(vq[i].din, a);
                    chk($sformatf("ack[%0d]", i), 16'(a), 16'(vq[i].exp[0]));
                end
                OP_RD: begin
                    i2c_rd(vq[i].din[0], d, rel);
                    chk($sformatf("rd_data[%0d]", i), 16'(d), 16'(vq[i].exp));
                    chk($sformatf("mack_release[%0d]", i), 16'(rel), 16'd1);
                end
                default: chk($sformatf("busy[%0d]", i), 16'(busy_a), 16'(vq[i].exp[0]));
            endcase
        end
    endtask

    task automatic sb_pop(input logic dev, input logic [15:0] a, input logic [7:0] d);
        wr_t e;
        if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL wr_strobe: unexpected dev %0d addr %h data %h, none required", dev, a, d);
        end else begin
            e = sb.pop_front();
            chk("wr_dev", 16'(dev), 16'(e.dev));
            chk("wr_addr", a, e.addr);
            chk("wr_data", 16'(d), 16'(e.data));
        end
    endtask

    always @(negedge clk) begin
        if (vld_a) sb_pop(1'b0, addr_a, data_a);
        if (vld_b) sb_pop(1'b1, addr_b, data_b);
        if (quiet_on && (oe_a || oe_b)) quiet_bad = 1'b1;
    end

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish within cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int m[9];
        logic s;
        // Stimulus table
        m[0] = vq.size();
        vs(); vw(8'h42); vw(8'h12); vws(8'h80, 1'b0, 16'h0012); vb(1'b1); vp(); vb(1'b0);
        vs(); vw(8'h42); vw(8'h12); vs(); vw(8'h43); vr(1'b1, 8'h80); vp();
        m[1] = vq.size();
        vs(); vw(8'h60, 1'b1); vw(8'h12, 1'b1); vp();
        m[2] = vq.size();
        vs(); vw(8'h42); vw(8'h30); vws(8'h5A, 1'b0, 16'h0030); vp();
        vs(); vw(8'h42); vw(8'h30); vs(); vw(8'h43); vr(1'b0, 8'h5A); vr(1'b1, 8'h00); vp();
        vs(); vw(8'h44); vw(8'h1F); vws(8'h11, 1'b1, 16'h001F); vws(8'h22, 1'b1, 16'h0000);
        vws(8'h33, 1'b1, 16'h0001); vp();
        vs(); vw(8'h44); vw(8'h1F); vs(); vw(8'h45); vr(1'b0, 8'h11); vr(1'b0, 8'h22); vr(1'b1, 8'h33); vp();
        vs(); vw(8'h44); vw(8'h1F); vp(); vs(); vw(8'h45); vr(1'b1, 8'h11); vp();
        m[3] = vq.size();
        vs(); vw(8'h42); vw(8'h12); vs(); vw(8'h43);
        m[4] = vq.size();
        vs(); vw(8'h42); vw(8'h12); vs(); vw(8'h43); vr(1'b1, 8'h00); vp();
        m[5] = vq.size();
`ifdef OVA_TGT_ID_REG_EN
        vs(); vw(8'h42); vw(8'h0A); vw(8'h55); vp();
        vs(); vw(8'h42); vw(8'h0A); vs(); vw(8'h43); vr(1'b0, 8'h76); vr(1'b1, 8'h73); vp();
`endif
        m[6] = vq.size();

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_oe", 16'(oe_a), 16'd0);
        chk("rst_busy", 16'(busy_a), 16'd0);
        chk("rst_vld", 16'(vld_a), 16'd0);
        chk("rst_addr", addr_a, 16'h0000);
        chk("rst_data", 16'(data_a), 16'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        run(m[0], m[1]);
        quiet_on = 1'b1;
        run(m[1], m[2]);
        quiet_on = 1'b0;
        chk("mismatch_quiet", 16'(quiet_bad), 16'd0);
        run(m[2], m[4]);

        // Reset while driving a zero data bit (bit 3 of 0x80) of a read
        for (int i = 0; i < 4; i++) bit_out(1'b1, s);
        wq();
        chk("pre_rst_oe", 16'(oe_a), 16'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_oe", 16'(oe_a), 16'd0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        run(m[4], m[6]);

        repeat (20) @(negedge clk);
        chk("sb_empty", 16'(sb.size()), 16'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
